// File: rtl/uart_tx_stream_if.sv
// Valid/ready word stream between a producer and the UART transmitter.
interface uart_tx_stream_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] i_data;
    logic                 i_valid;
    logic                 o_ready;

    modport master (output i_data, output i_valid, input o_ready);
    modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/uart_tx_stream.sv
// Parametrised UART transmitter with an input FIFO; frames stream back-to-back
// with no idle gap while the FIFO holds data.
module uart_tx_stream #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4,
    localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    uart_tx_stream_if.slave         i_stream,
    output logic                    o_tx,
    output logic                    o_busy,
    output logic [LVL_W-1:0]        o_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_stream: DATA_BITS must be in 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_stream: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_stream: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_stream: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx_stream: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               r_state, w_state_next;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]     r_level, w_level_next;
    logic                 r_ready;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic                 r_parity, w_parity_next;
    logic [CNT_W-1:0]     r_clk_cnt, w_clk_cnt_next;
    logic [BIT_W-1:0]     r_bit_cnt, w_bit_cnt_next;
    logic                 r_tx, w_tx_next;
    logic                 r_busy;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_push, w_pop, w_load, w_full, w_empty, w_bit_end;

    // Full/ready come from registered occupancy, so a pop never frees a slot early.
    assign w_full       = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty      = (r_level == '0);
    assign w_push       = i_stream.i_valid && !w_full;
    assign w_level_next = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_bit_end    = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_next;
            r_ready <= (w_level_next != LVL_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_stream.i_data;
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_clk_cnt_next = r_clk_cnt;
        w_bit_cnt_next = r_bit_cnt;
        w_tx_next      = r_tx;
        w_load         = 1'b0;
        w_pop          = 1'b0;

        if (r_state != StIdle) begin
            w_clk_cnt_next = w_bit_end ? '0 : r_clk_cnt + 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                w_load = !w_empty;
            end
            StStart: begin
                if (w_bit_end) begin
                    w_state_next = StData;
                    w_tx_next    = r_shift[0];
                end
            end
            StData: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        w_bit_cnt_next = '0;
                        if (PARITY != 0) begin
                            w_state_next = StParity;
                            w_tx_next    = r_parity;
                        end else begin
                            w_state_next = StStop;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                        w_shift_next   = r_shift >> 1;
                        w_tx_next      = r_shift[1];
                    end
                end
            end
            StParity: begin
                if (w_bit_end) begin
                    w_state_next = StStop;
                    w_tx_next    = 1'b1;
                end
            end
            StStop: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = StIdle;
                        w_tx_next      = 1'b1;
                        w_load         = !w_empty;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
                w_tx_next    = 1'b1;
            end
        endcase

        // Loading from the last stop cycle starts the next frame with no idle gap.
        if (w_load) begin
            w_pop          = 1'b1;
            w_shift_next   = w_head;
            w_parity_next  = (PARITY == 1) ? ~(^w_head) : ^w_head;
            w_state_next   = StStart;
            w_clk_cnt_next = '0;
            w_tx_next      = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tx      <= w_tx_next;
            r_busy    <= (w_state_next != StIdle);
        end
    end

    assign i_stream.o_ready = r_ready;
    assign o_tx             = r_tx;
    assign o_busy           = r_busy;
    assign o_level          = r_level;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: three configurations checked every cycle against a
// frame-queue model, plus directed literal expectations.
module tb_uart_tx_stream;

    localparam int NI    = 3;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int DB  [NI] = '{8, 8, 5};
    localparam int PAR [NI] = '{2, 1, 0};
    localparam int STP [NI] = '{1, 2, 1};

    logic       clk;
    logic       rst;
    logic [8:0] tb_data  [NI];
    logic       tb_valid [NI];
    logic       dut_tx    [NI];
    logic       dut_busy  [NI];
    logic       dut_ready [NI];
    logic [2:0] dut_level [NI];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    uart_tx_stream_if #(.DATA_BITS(8)) if0 ();
    uart_tx_stream_if #(.DATA_BITS(8)) if1 ();
    uart_tx_stream_if #(.DATA_BITS(5)) if2 ();

    assign if0.i_data  = tb_data[0][7:0];
    assign if0.i_valid = tb_valid[0];
    assign dut_ready[0] = if0.o_ready;
    assign if1.i_data  = tb_data[1][7:0];
    assign if1.i_valid = tb_valid[1];
    assign dut_ready[1] = if1.o_ready;
    assign if2.i_data  = tb_data[2][4:0];
    assign if2.i_valid = tb_valid[2];
    assign dut_ready[2] = if2.o_ready;

    uart_tx_stream #(
        .DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_even (
        .i_clk(clk), .i_rst(rst), .i_stream(if0),
        .o_tx(dut_tx[0]), .o_busy(dut_busy[0]), .o_level(dut_level[0])
    );

    uart_tx_stream #(
        .DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u_odd (
        .i_clk(clk), .i_rst(rst), .i_stream(if1),
        .o_tx(dut_tx[1]), .o_busy(dut_busy[1]), .o_level(dut_level[1])
    );

    uart_tx_stream #(
        .DATA_BITS(5), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_narrow (
        .i_clk(clk), .i_rst(rst), .i_stream(if2),
        .o_tx(dut_tx[2]), .o_busy(dut_busy[2]), .o_level(dut_level[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: words waiting in the FIFO, and the remaining per-cycle line values of
    // the frame on the wire (front = value in the current cycle).
    int   m_fifo [NI][$];
    logic m_line [NI][$];
    logic exp_tx    [NI] = '{1'b1, 1'b1, 1'b1};
    logic exp_busy  [NI] = '{1'b0, 1'b0, 1'b0};
    logic exp_ready [NI] = '{1'b1, 1'b1, 1'b1};
    int   exp_level [NI] = '{0, 0, 0};

    task automatic append_frame(input int k, input int w);
        logic bits [$];
        int   ones;
        bits.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < DB[k]; i++) begin
            bits.push_back(((w >> i) & 1) != 0);
            ones += (w >> i) & 1;
        end
        if (PAR[k] == 1) bits.push_back((ones % 2) == 0);
        if (PAR[k] == 2) bits.push_back((ones % 2) == 1);
        for (int s = 0; s < STP[k]; s++) bits.push_back(1'b1);
        foreach (bits[i]) for (int c = 0; c < CPB; c++) m_line[k].push_back(bits[i]);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                m_fifo[k].delete();
                m_line[k].delete();
                exp_tx[k]    = 1'b1;
                exp_busy[k]  = 1'b0;
                exp_ready[k] = 1'b1;
                exp_level[k] = 0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                int n_before;
                n_before = m_fifo[k].size();
                if (m_line[k].size() != 0) void'(m_line[k].pop_front());
                if (m_line[k].size() == 0 && n_before != 0) append_frame(k, m_fifo[k].pop_front());
                if (tb_valid[k] && n_before < DEPTH)
                    m_fifo[k].push_back(int'(tb_data[k]) & ((1 << DB[k]) - 1));
                exp_tx[k]    = (m_line[k].size() != 0) ? m_line[k][0] : 1'b1;
                exp_busy[k]  = (m_line[k].size() != 0);
                exp_level[k] = m_fifo[k].size();
                exp_ready[k] = (m_fifo[k].size() < DEPTH);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("u%0d tx", k),    32'(dut_tx[k]),    32'(exp_tx[k]));
                check($sformatf("u%0d busy", k),  32'(dut_busy[k]),  32'(exp_busy[k]));
                check($sformatf("u%0d ready", k), 32'(dut_ready[k]), 32'(exp_ready[k]));
                check($sformatf("u%0d level", k), 32'(dut_level[k]), 32'(exp_level[k]));
            end
        end
    end

    // Push one word into an idle instance and pin the line against a literal bit list.
    task automatic frame_test(input string name, input int k, input logic [8:0] w,
                              input logic [15:0] seq, input int nbits);
        tb_data[k]  = w;
        tb_valid[k] = 1'b1;
        @(negedge clk);
        tb_valid[k] = 1'b0;
        check({name, " level at push+1"}, 32'(dut_level[k]), 1);
        check({name, " tx at push+1"}, 32'(dut_tx[k]), 1);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                check($sformatf("%s bit%0d c%0d", name, i, c), 32'(dut_tx[k]), 32'(seq[i]));
                check($sformatf("%s busy bit%0d", name, i), 32'(dut_busy[k]), 1);
            end
        end
        @(negedge clk);
        check({name, " busy after frame"}, 32'(dut_busy[k]), 0);
        check({name, " tx after frame"}, 32'(dut_tx[k]), 1);
    endtask

    initial begin
        logic [8:0] words [6];
        int         acc   [6];
        int         guard;

        words = '{9'h001, 9'h080, 9'h03C, 9'h0FF, 9'h000, 9'h05A};
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            tb_data[k]  = '0;
            tb_valid[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset u%0d tx", k),    32'(dut_tx[k]),    1);
            check($sformatf("reset u%0d ready", k), 32'(dut_ready[k]), 1);
            check($sformatf("reset u%0d busy", k),  32'(dut_busy[k]),  0);
            check($sformatf("reset u%0d level", k), 32'(dut_level[k]), 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        frame_test("even A5", 0, 9'h0A5, 16'h054A, 11);
        frame_test("odd A5 2stop", 1, 9'h0A5, 16'h0F4A, 12);
        frame_test("narrow 13", 2, 9'h013, 16'h0066, 7);

        // Backpressure: six words offered back-to-back from idle.
        for (int w = 0; w < 6; w++) begin
            tb_data[0]  = words[w];
            tb_valid[0] = 1'b1;
            guard = 0;
            while (dut_ready[0] !== 1'b1 && guard < 400) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 400) check($sformatf("bp word%0d ready timeout", w), 0, 1);
            acc[w] = cyc;
            @(negedge clk);
            if (w == 4) check("bp ready low after word4", 32'(dut_ready[0]), 0);
        end
        tb_valid[0] = 1'b0;
        check("bp words0-4 consecutive", 32'(acc[4] - acc[0]), 4);
        check("bp word5 accept cycle", 32'(acc[5] - acc[0]), 46);
        guard = 0;
        while ((dut_busy[0] !== 1'b0 || dut_level[0] !== 3'd0) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("bp drained", 32'(guard < 400), 1);
        check("bp drain time", 32'(cyc - acc[0]), 6 * 44 + 2);

        // Asynchronous reset in the middle of an all-zero frame with a word queued.
        tb_data[2]  = 9'h000;
        tb_valid[2] = 1'b1;
        @(negedge clk);
        tb_data[2]  = 9'h01F;
        @(negedge clk);
        tb_valid[2] = 1'b0;
        repeat (10) @(negedge clk);
        check("pre-reset tx low", 32'(dut_tx[2]), 0);
        #2 rst = 1'b1;
        #1;
        check("async reset tx", 32'(dut_tx[2]), 1);
        check("async reset busy", 32'(dut_busy[2]), 0);
        check("async reset level", 32'(dut_level[2]), 0);
        check("async reset ready", 32'(dut_ready[2]), 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check($sformatf("post-reset idle c%0d", i), 32'(dut_tx[2]), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
